msg_fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the single `msg_fifo` write port among `NUM_SRC` parser lanes. Each lane offers `parsed_msg_t` words over valid/ready. The arbiter grants one lane per cycle, with optional per-lane bursts so a lane's messages stay contiguous in the FIFO. It also back-pressures every lane from `fifo_full` and keeps per-lane accept counters and a global stall counter for debug.

---
 rtl/parser_defs.sv | 20 ++
 rtl/rr_pick.sv | 27 ++
 rtl/msg_fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_msg_fifo_wr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_defs.sv
// Shared message and arbiter types for the parser-to-FIFO path.
package parser_defs;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic [31:0] order_id;
        logic [31:0] price;
        logic [15:0] qty;
    } parsed_msg_t;

    localparam int MAX_SRC = 16;

    typedef logic [$clog2(MAX_SRC)-1:0] src_idx_t;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic find-first: the first set request at or after start, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    function automatic logic [IDX_W-1:0] wrap(input int s);
        return (s >= N) ? IDX_W'(s - N) : IDX_W'(s);
    endfunction

    // Scan from the far end so the nearest hit to start is written last.
    always_comb begin
        idx = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap(int'(start) + k)]) begin
                idx = wrap(int'(start) + k);
            end
        end
    end

endmodule

// File: rtl/msg_fifo_wr_arbiter.sv
// Round-robin, burst-capable arbiter sharing the msg_fifo write port among parser lanes.
module msg_fifo_wr_arbiter
    import parser_defs::*;
#(
    parameter int  NUM_SRC   = 4,
    parameter int  MAX_BURST = 4,
    parameter int  CNT_W     = 16,
    localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_valid,
    input  parsed_msg_t        src_msg [NUM_SRC],
    output logic [NUM_SRC-1:0] src_ready,
    input  logic               fifo_full,
    output logic               fifo_write_en,
    output parsed_msg_t        fifo_msg_in,
    output logic [IDX_W-1:0]   grant_id,
    output logic [CNT_W-1:0]   accept_cnt [NUM_SRC],
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [BEAT_W-1:0] beats_q, beats_d, beats_inc;
    logic [IDX_W-1:0]  pick_start, pick_idx, grant;
    logic              owner_vld, burst_hold, burst_drop, pick_any, xfer;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) >= NUM_SRC - 1) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign owner_vld  = src_valid[owner_q];
    assign burst_hold = (state_q == BURST) && owner_vld;
    assign burst_drop = (state_q == BURST) && !owner_vld;

    // An abandoned burst hands over in the same cycle by picking from owner+1.
    assign pick_start = burst_drop ? next_idx(owner_q) : rr_ptr_q;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req   (src_valid),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign grant         = burst_hold ? owner_q : pick_idx;
    assign xfer          = pick_any && !fifo_full && reset;
    assign fifo_write_en = xfer;
    assign fifo_msg_in   = src_msg[grant];
    assign grant_id      = reset ? grant : '0;
    assign beats_inc     = beats_q + 1'b1;

    always_comb begin
        src_ready = '0;
        if (xfer) begin
            src_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        beats_d  = beats_q;
        if (burst_drop) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(owner_q);
            beats_d  = '0;
        end
        // Back-pressure leaves everything untouched, so a burst survives fifo_full.
        if (xfer) begin
            if (burst_hold) begin
                beats_d = beats_inc;
                if (beats_inc == BEAT_W'(MAX_BURST)) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(owner_q);
                    beats_d  = '0;
                end
            end else if (MAX_BURST > 1) begin
                state_d = BURST;
                owner_d = grant;
                beats_d = BEAT_W'(1);
            end else begin
                rr_ptr_d = next_idx(grant);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            beats_q   <= '0;
            stall_cnt <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            beats_q  <= beats_d;
            if (pick_any && fifo_full) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_acc
        always_ff @(posedge clk) begin
            if (!reset) begin
                accept_cnt[i] <= '0;
            end else if (src_ready[i]) begin
                accept_cnt[i] <= sat_inc(accept_cnt[i]);
            end
        end
    end

endmodule

// File: tb/tb_msg_fifo_wr_arbiter.sv
// Bench for msg_fifo_wr_arbiter: three configurations checked every cycle against a lane-level model.
module tb_msg_fifo_wr_arbiter;
    import parser_defs::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  valid [3];
    logic        full  [3];
    parsed_msg_t msg_a [4];
    parsed_msg_t msg_b [4];
    parsed_msg_t msg_c [4];
    logic [3:0]  ready [3];
    logic        we    [3];
    parsed_msg_t mout  [3];
    logic [1:0]  gid   [3];
    logic [15:0] acc_a [4];
    logic [15:0] acc_b [4];
    logic [3:0]  acc_c [4];
    logic [15:0] stall_a, stall_b;
    logic [3:0]  stall_c;

    always #5 clk = ~clk;

    // a: bursts of 4; b: pure round-robin; c: bursts of 4 with 4-bit counters
    msg_fifo_wr_arbiter #(.NUM_SRC(4), .MAX_BURST(4), .CNT_W(16)) u_a (
        .clk(clk), .reset(rst_n), .src_valid(valid[0]), .src_msg(msg_a), .src_ready(ready[0]),
        .fifo_full(full[0]), .fifo_write_en(we[0]), .fifo_msg_in(mout[0]), .grant_id(gid[0]),
        .accept_cnt(acc_a), .stall_cnt(stall_a));
    msg_fifo_wr_arbiter #(.NUM_SRC(4), .MAX_BURST(1), .CNT_W(16)) u_b (
        .clk(clk), .reset(rst_n), .src_valid(valid[1]), .src_msg(msg_b), .src_ready(ready[1]),
        .fifo_full(full[1]), .fifo_write_en(we[1]), .fifo_msg_in(mout[1]), .grant_id(gid[1]),
        .accept_cnt(acc_b), .stall_cnt(stall_b));
    msg_fifo_wr_arbiter #(.NUM_SRC(4), .MAX_BURST(4), .CNT_W(4)) u_c (
        .clk(clk), .reset(rst_n), .src_valid(valid[2]), .src_msg(msg_c), .src_ready(ready[2]),
        .fifo_full(full[2]), .fifo_write_en(we[2]), .fifo_msg_in(mout[2]), .grant_id(gid[2]),
        .accept_cnt(acc_c), .stall_cnt(stall_c));

    int         mb   [3] = '{4, 1, 4};
    int         cmax [3] = '{65535, 65535, 15};
    int         m_rr [3];
    bit         m_burst [3];
    int         m_owner [3];
    int         m_beats [3];
    int         m_acc [3][4];
    int         m_stall [3];
    logic [3:0] exp_rdy [3];
    int         checks = 0;
    int         errors = 0;
    int         glog_a [$];
    int         glog_b [$];
    int         glog_c [$];
    int         olog_a [$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit vbit(input logic [3:0] v, input int i);
        return v[i[1:0]];
    endfunction

    function automatic parsed_msg_t get_msg(input int d, input int i);
        case (d)
            0:       return msg_a[i];
            1:       return msg_b[i];
            default: return msg_c[i];
        endcase
    endfunction

    task automatic set_msg(input int d, input int i, input parsed_msg_t m);
        case (d)
            0:       msg_a[i] = m;
            1:       msg_b[i] = m;
            default: msg_c[i] = m;
        endcase
    endtask

    function automatic int dut_acc(input int d, input int i);
        case (d)
            0:       return int'(acc_a[i]);
            1:       return int'(acc_b[i]);
            default: return int'(acc_c[i]);
        endcase
    endfunction

    function automatic int dut_stall(input int d);
        case (d)
            0:       return int'(stall_a);
            1:       return int'(stall_b);
            default: return int'(stall_c);
        endcase
    endfunction

    // Lane-level model: predict this cycle's outputs, compare, then advance to the next edge.
    always @(negedge clk) begin
        bit any, hold, xfer;
        int start, g;
        for (int d = 0; d < 3; d++) begin
            any   = (valid[d] != 4'b0);
            hold  = m_burst[d] && vbit(valid[d], m_owner[d]);
            start = m_burst[d] ? (m_owner[d] + 1) % 4 : m_rr[d];
            g     = start;
            for (int k = 3; k >= 0; k--) begin
                if (vbit(valid[d], (start + k) % 4)) g = (start + k) % 4;
            end
            if (hold) g = m_owner[d];
            xfer = rst_n && any && !full[d];
            exp_rdy[d] = xfer ? 4'(1 << g) : 4'b0;

            chk($sformatf("write_en[%0d]", d), 96'(we[d]), 96'(xfer));
            chk($sformatf("src_ready[%0d]", d), 96'(ready[d]), 96'(exp_rdy[d]));
            if (!rst_n) chk($sformatf("grant_rst[%0d]", d), 96'(gid[d]), 96'(0));
            if (xfer) begin
                chk($sformatf("grant_id[%0d]", d), 96'(gid[d]), 96'(g));
                chk($sformatf("fifo_msg[%0d]", d), 96'(mout[d]), 96'(get_msg(d, g)));
                case (d)
                    0: begin glog_a.push_back(int'(gid[d])); olog_a.push_back(int'(mout[d].order_id)); end
                    1: glog_b.push_back(int'(gid[d]));
                    default: glog_c.push_back(int'(gid[d]));
                endcase
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("accept_cnt[%0d][%0d]", d, i), 96'(dut_acc(d, i)), 96'(m_acc[d][i]));
            end
            chk($sformatf("stall_cnt[%0d]", d), 96'(dut_stall(d)), 96'(m_stall[d]));

            if (!rst_n) begin
                m_rr[d] = 0; m_burst[d] = 0; m_owner[d] = 0; m_beats[d] = 0; m_stall[d] = 0;
                for (int i = 0; i < 4; i++) m_acc[d][i] = 0;
            end else begin
                if (m_burst[d] && !hold) begin
                    m_burst[d] = 0;
                    m_rr[d]    = (m_owner[d] + 1) % 4;
                end
                if (xfer) begin
                    if (m_acc[d][g] < cmax[d]) m_acc[d][g]++;
                    if (hold) begin
                        m_beats[d]++;
                        if (m_beats[d] == mb[d]) begin
                            m_burst[d] = 0;
                            m_rr[d]    = (m_owner[d] + 1) % 4;
                        end
                    end else if (mb[d] > 1) begin
                        m_burst[d] = 1; m_owner[d] = g; m_beats[d] = 1;
                    end else begin
                        m_rr[d] = (g + 1) % 4;
                    end
                end
                if (any && full[d] && m_stall[d] < cmax[d]) m_stall[d]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            valid[d] = 4'b0;
            full[d]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Lanes hold each word until accepted; lane i's k-th word has order_id i*256+k.
    task automatic drive_words(input int d, input int n0, input int n1, input int n2, input int n3,
                               input int cycles, input int fs, input int fl);
        int rem [4];
        int seq [4];
        parsed_msg_t m;
        rem = '{n0, n1, n2, n3};
        seq = '{0, 0, 0, 0};
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 4; i++) begin
                valid[d][i[1:0]] = (rem[i] > 0);
                m.msg_type = 8'(i);
                m.order_id = 32'(i * 256 + seq[i]);
                m.price    = 32'(seq[i] * 3);
                m.qty      = 16'(seq[i]);
                set_msg(d, i, m);
            end
            full[d] = (c >= fs) && (c < fs + fl);
            tick();
            for (int i = 0; i < 4; i++) begin
                if (vbit(exp_rdy[d], i)) begin
                    rem[i]--;
                    seq[i]++;
                end
            end
        end
        valid[d] = 4'b0;
        full[d]  = 1'b0;
    endtask

    initial begin
        parsed_msg_t m;
        int exp_burst [12] = '{'h000, 'h001, 'h002, 'h003, 'h200, 'h201, 'h202, 'h203,
                               'h004, 'h005, 'h204, 'h205};
        int exp_early [4] = '{1, 1, 3, 3};
        int exp_bp    [7] = '{0, 0, 0, 0, 1, 1, 1};
        for (int d = 0; d < 3; d++) exp_rdy[d] = 4'b0;
        idle_all();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                m = '0;
                m.order_id = 32'('h1000 + i);
                set_msg(d, i, m);
            end
        end

        // reset held with every lane requesting
        for (int d = 0; d < 3; d++) valid[d] = 4'hf;
        tick();
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("rst_write_en", 96'(we[0]), 96'(0));
            chk("rst_src_ready", 96'(ready[0]), 96'(0));
            chk("rst_accept0", 96'(acc_a[0]), 96'(0));
            chk("rst_stall", 96'(stall_a), 96'(0));
            tick();
        end
        rst_n = 1'b1;
        #2;
        chk("post_rst_we", 96'(we[0]), 96'(1));
        chk("post_rst_grant", 96'(gid[0]), 96'(0));
        tick();

        // pure round-robin
        do_reset();
        valid[1] = 4'hf;
        glog_b.delete();
        repeat (8) tick();
        valid[1] = 4'b0;
        chk("rr_len", 96'(glog_b.size()), 96'(8));
        for (int k = 0; k < 8 && k < glog_b.size(); k++) chk($sformatf("rr_grant%0d", k), 96'(glog_b[k]), 96'(k % 4));
        for (int i = 0; i < 4; i++) chk($sformatf("rr_accept%0d", i), 96'(acc_b[i]), 96'(2));

        // bursts interleave as 4,4,2,2
        do_reset();
        olog_a.delete();
        drive_words(0, 6, 0, 6, 0, 16, 0, 0);
        chk("burst_len", 96'(olog_a.size()), 96'(12));
        for (int k = 0; k < 12 && k < olog_a.size(); k++) chk($sformatf("burst_oid%0d", k), 96'(olog_a[k]), 96'(exp_burst[k]));

        // owner drops mid-burst: next lane granted with no bubble
        do_reset();
        glog_a.delete();
        drive_words(0, 0, 2, 0, 10, 4, 0, 0);
        chk("early_len", 96'(glog_a.size()), 96'(4));
        for (int k = 0; k < 4 && k < glog_a.size(); k++) chk($sformatf("early_grant%0d", k), 96'(glog_a[k]), 96'(exp_early[k]));
        chk("early_rr_ptr", 96'(u_a.rr_ptr_q), 96'(2));
        chk("early_model_rr", 96'(m_rr[0]), 96'(2));

        // back-pressure mid-burst
        do_reset();
        glog_a.delete();
        drive_words(0, 20, 20, 0, 0, 12, 2, 5);
        chk("bp_stall", 96'(stall_a), 96'(5));
        chk("bp_len", 96'(glog_a.size()), 96'(7));
        for (int k = 0; k < 7 && k < glog_a.size(); k++) chk($sformatf("bp_grant%0d", k), 96'(glog_a[k]), 96'(exp_bp[k]));

        // reset mid-burst: lowest valid lane wins afterwards
        do_reset();
        valid[0] = 4'b0100;
        tick();
        tick();
        rst_n = 1'b0;
        valid[0] = 4'b0110;
        tick();
        rst_n = 1'b1;
        #2;
        chk("rst_mid_grant", 96'(gid[0]), 96'(1));
        chk("rst_mid_we", 96'(we[0]), 96'(1));
        tick();
        valid[0] = 4'b0;

        // counter saturation and pointer wrap
        do_reset();
        glog_c.delete();
        drive_words(2, 0, 0, 0, 20, 24, 0, 0);
        chk("sat_len", 96'(glog_c.size()), 96'(20));
        chk("sat_accept3", 96'(acc_c[3]), 96'(15));
        chk("sat_model", 96'(m_acc[2][3]), 96'(15));
        chk("wrap_rr_ptr", 96'(u_c.rr_ptr_q), 96'(0));

        // randomized traffic on all three configurations
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(99) != 0);
            for (int d = 0; d < 3; d++) begin
                full[d] = ($urandom_range(3) == 0);
                for (int i = 0; i < 4; i++) begin
                    if (!(vbit(valid[d], i) && !vbit(exp_rdy[d], i) && $urandom_range(7) != 0)) begin
                        valid[d][i[1:0]] = 1'($urandom_range(1));
                        m.msg_type = 8'($urandom);
                        m.order_id = $urandom;
                        m.price    = $urandom;
                        m.qty      = 16'($urandom);
                        set_msg(d, i, m);
                    end
                end
            end
            tick();
        end
        rst_n = 1'b1;
        idle_all();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
